// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
//
// Time-multiplexes an 8-digit common-anode seven-segment display. Each digit
// goes through a BLANK phase (all segments off, suppresses ghosting while the
// anode driver switches) and then a SHOW phase. The 32-bit display word is
// double-buffered: a word accepted over the valid/ready handshake is parked in
// a pending buffer and only becomes visible at a frame boundary, so a frame is
// never drawn from two different words.
//
// Parameters:
//   TICKS_PER_DIGIT  cycles each digit is lit (>= 1)
//   BLANK_TICKS      cycles of blanking before each digit (0 disables blanking)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   data_in      display word, nibble k is the value for digit k
//   data_valid   data_in is valid
//   data_ready   a word can be accepted (pending buffer empty)
//   digit_en     per-digit enable, 0 forces that digit blank
//   count_an     current digit index for the anode decoder
//   digit_value  nibble of the active word selected by count_an
//   digit_blank  1 = drive all segments off
//   frame_done   one-cycle pulse on the first cycle of each new frame
module display_scan_scheduler #(
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [7:0]  digit_en,
  output logic [2:0]  count_an,
  output logic [3:0]  digit_value,
  output logic        digit_blank,
  output logic        frame_done
);

  localparam bit          HasBlank = (BLANK_TICKS != 0);
  localparam int unsigned MaxTicks = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT
                                                                     : BLANK_TICKS;
  // The tick counter only ever holds 0..N-1, so $clog2(N) bits suffice.
  localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  localparam logic [TickW-1:0] ShowLast  = TickW'(TICKS_PER_DIGIT - 1);
  localparam logic [TickW-1:0] BlankLast = TickW'(HasBlank ? BLANK_TICKS - 1 : 0);

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } state_e;

  state_e             state_q;
  logic [TickW-1:0]   tick_q;
  logic [2:0]         count_q;
  logic [31:0]        active_q;
  logic [31:0]        pending_q;
  logic               pending_full_q;
  logic               frame_done_q;

  logic               show_end;
  logic               frame_wrap;
  logic               xfer;

  assign data_ready = ~pending_full_q;
  assign xfer       = data_valid & ~pending_full_q;

  // Last SHOW cycle of a digit; on digit 7 this edge is the frame boundary.
  assign show_end   = (state_q == StShow) && (tick_q == ShowLast);
  assign frame_wrap = show_end && (count_q == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      if (HasBlank) begin
        state_q <= StBlank;
      end else begin
        state_q <= StShow;
      end
      tick_q         <= '0;
      count_q        <= 3'd0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= frame_wrap;

      // Scan sequencing.
      unique case (state_q)
        StBlank: begin
          if (tick_q == BlankLast) begin
            state_q <= StShow;
            tick_q  <= '0;
          end else begin
            tick_q <= tick_q + TickW'(1);
          end
        end
        StShow: begin
          if (show_end) begin
            tick_q  <= '0;
            count_q <= count_q + 3'd1;
            if (HasBlank) begin
              state_q <= StBlank;
            end
          end else begin
            tick_q <= tick_q + TickW'(1);
          end
        end
        default: begin
          state_q <= StBlank;
          tick_q  <= '0;
        end
      endcase

      // Double buffer. A word arriving on the boundary edge itself with the
      // pending buffer empty bypasses the buffer so it is not delayed a frame.
      if (frame_wrap) begin
        if (pending_full_q) begin
          active_q       <= pending_q;
          pending_full_q <= 1'b0;
        end else if (xfer) begin
          active_q <= data_in;
        end
      end else if (xfer) begin
        pending_q      <= data_in;
        pending_full_q <= 1'b1;
      end
    end
  end

  assign count_an    = count_q;
  assign frame_done  = frame_done_q;
  assign digit_value = active_q[4*count_q +: 4];
  assign digit_blank = (state_q == StBlank) | ~digit_en[count_q];

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler. The stimulus process queues
// expected values keyed by (reset epoch, cycle after reset release); the
// monitor samples on the falling edge and checks every queued entry whose
// stamp matches. A second instance covers the BLANK_TICKS=0 variant.
module tb_display_scan_scheduler;

  localparam int KCnt    = 0;
  localparam int KBlank  = 1;
  localparam int KFd     = 2;
  localparam int KRdy    = 3;
  localparam int KVal    = 4;
  localparam int KCntNb  = 5;
  localparam int KBlankNb = 6;
  localparam int KFdNb   = 7;
  localparam int KSeenNb = 8;

  typedef struct {
    int          stamp;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = 32'h0;
  logic        data_valid = 1'b0;
  logic [7:0]  digit_en = 8'hFF;

  logic        data_ready, digit_blank, frame_done;
  logic [2:0]  count_an;
  logic [3:0]  digit_value;
  logic        data_ready_nb, digit_blank_nb, frame_done_nb;
  logic [2:0]  count_an_nb;
  logic [3:0]  digit_value_nb;

  exp_t q[$];
  int   cyc = 0;
  int   epoch = 0;
  int   errors = 0;
  int   checks = 0;
  bit   blank_nb_seen = 1'b0;

  display_scan_scheduler #(.TICKS_PER_DIGIT(4), .BLANK_TICKS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .digit_en   (digit_en),
    .count_an   (count_an),
    .digit_value(digit_value),
    .digit_blank(digit_blank),
    .frame_done (frame_done)
  );

  display_scan_scheduler #(.TICKS_PER_DIGIT(4), .BLANK_TICKS(0)) dut_nb (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready_nb),
    .digit_en   (digit_en),
    .count_an   (count_an_nb),
    .digit_value(digit_value_nb),
    .digit_blank(digit_blank_nb),
    .frame_done (frame_done_nb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic string kname(input int k);
    case (k)
      KCnt:     return "count_an";
      KBlank:   return "digit_blank";
      KFd:      return "frame_done";
      KRdy:     return "data_ready";
      KVal:     return "digit_value";
      KCntNb:   return "nb_count_an";
      KBlankNb: return "nb_digit_blank";
      KFdNb:    return "nb_frame_done";
      default:  return "nb_blank_ever_seen";
    endcase
  endfunction

  function automatic void expect_at(input int ep, input int c, input int k,
                                    input logic [31:0] v);
    exp_t e;
    e.stamp = ep * 1000000 + c;
    e.kind  = k;
    e.exp   = v;
    q.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    int          cur;
    if (!reset) begin
      if (digit_blank_nb) blank_nb_seen = 1'b1;
      cur = epoch * 1000000 + cyc;
      while (q.size() > 0 && q[0].stamp <= cur) begin
        e = q.pop_front();
        checks++;
        if (e.stamp < cur) begin
          errors++;
          $display("FAIL %s: check at stamp %0d never sampled (now %0d), expected %0h",
                   kname(e.kind), e.stamp, cur, e.exp);
        end else begin
          case (e.kind)
            KCnt:     act = 32'(count_an);
            KBlank:   act = 32'(digit_blank);
            KFd:      act = 32'(frame_done);
            KRdy:     act = 32'(data_ready);
            KVal:     act = 32'(digit_value);
            KCntNb:   act = 32'(count_an_nb);
            KBlankNb: act = 32'(digit_blank_nb);
            KFdNb:    act = 32'(frame_done_nb);
            default:  act = 32'(blank_nb_seen);
          endcase
          if (act !== e.exp) begin
            errors++;
            $display("FAIL %s @epoch %0d cycle %0d: got %0h expected %0h",
                     kname(e.kind), epoch, cyc, act, e.exp);
          end
        end
      end
    end
  end

  task automatic goto(input int c);
    int guard = 0;
    while (cyc != c) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 5000) begin
        $display("FAIL goto: cycle %0d not reached, at %0d", c, cyc);
        $fatal(1, "cycle bound expired");
      end
    end
  endtask

  task automatic start_phase(input int n);
    epoch++;
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic pulse(input int c, input logic [31:0] w);
    goto(c);
    data_in    = w;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in    = 32'hDEADBEEF;
  endtask

  initial begin
    // Phase A: scan timing, double buffer, boundary bypass, no-blank variant.
    expect_at(1, 0, KCnt, 0);     expect_at(1, 0, KBlank, 1);   expect_at(1, 0, KFd, 0);
    expect_at(1, 0, KRdy, 1);     expect_at(1, 0, KVal, 0);
    expect_at(1, 0, KCntNb, 0);   expect_at(1, 0, KBlankNb, 0); expect_at(1, 0, KFdNb, 0);
    expect_at(1, 1, KBlank, 1);
    expect_at(1, 2, KBlank, 0);
    expect_at(1, 3, KCntNb, 0);
    expect_at(1, 4, KCntNb, 1);
    expect_at(1, 5, KCnt, 0);     expect_at(1, 5, KBlank, 0);
    expect_at(1, 6, KCnt, 1);     expect_at(1, 6, KBlank, 1);
    expect_at(1, 11, KRdy, 0);
    expect_at(1, 31, KCntNb, 7);
    expect_at(1, 32, KCntNb, 0);  expect_at(1, 32, KFdNb, 1);
    expect_at(1, 33, KFdNb, 0);
    expect_at(1, 42, KCnt, 7);
    expect_at(1, 47, KCnt, 7);    expect_at(1, 47, KFd, 0);
    expect_at(1, 47, KVal, 0);    expect_at(1, 47, KRdy, 0);
    expect_at(1, 48, KCnt, 0);    expect_at(1, 48, KFd, 1);
    expect_at(1, 49, KFd, 0);     expect_at(1, 49, KRdy, 1);
    expect_at(1, 54, KVal, 1);
    expect_at(1, 90, KVal, 7);
    expect_at(1, 96, KCnt, 0);    expect_at(1, 96, KFd, 1);
    expect_at(1, 96, KVal, 8);    expect_at(1, 96, KRdy, 1);
    expect_at(1, 97, KRdy, 1);    expect_at(1, 97, KFd, 0);
    expect_at(1, 100, KSeenNb, 0);
    expect_at(1, 102, KVal, 7);
    start_phase(3);
    pulse(10, 32'h76543210);
    pulse(95, 32'h12345678);
    goto(104);

    // Phase B: back-pressure with valid held high.
    expect_at(2, 30, KRdy, 0);
    expect_at(2, 47, KVal, 0);
    expect_at(2, 48, KRdy, 1);
    expect_at(2, 49, KRdy, 0);
    expect_at(2, 90, KVal, 7);
    expect_at(2, 95, KVal, 7);    expect_at(2, 95, KRdy, 0);
    expect_at(2, 96, KVal, 32'hA); expect_at(2, 96, KRdy, 1);
    expect_at(2, 97, KRdy, 0);
    start_phase(2);
    goto(10);
    data_in    = 32'h76543210;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in = 32'hAAAAAAAA;
    goto(97);
    data_valid = 1'b0;
    goto(100);

    // Phase C: digit 0 disabled, then reset mid-scan discards the pending word.
    expect_at(3, 0, KBlank, 1);   expect_at(3, 0, KCnt, 0);
    expect_at(3, 2, KBlank, 1);
    expect_at(3, 5, KBlank, 1);
    expect_at(3, 6, KBlank, 1);   expect_at(3, 6, KCnt, 1);
    expect_at(3, 8, KBlank, 0);
    expect_at(3, 29, KCnt, 4);    expect_at(3, 29, KRdy, 0);
    expect_at(4, 0, KCnt, 0);     expect_at(4, 0, KFd, 0);      expect_at(4, 0, KRdy, 1);
    expect_at(4, 0, KVal, 0);     expect_at(4, 0, KBlank, 1);
    expect_at(4, 8, KBlank, 0);
    expect_at(4, 48, KCnt, 0);    expect_at(4, 48, KFd, 1);
    expect_at(4, 54, KVal, 0);
    digit_en = 8'hFE;
    start_phase(2);
    pulse(5, 32'h76543210);
    goto(30);
    start_phase(1);
    goto(1);
    digit_en = 8'hFF;
    goto(58);

    if (q.size() > 0) begin
      $display("FAIL scoreboard: %0d expected entries never checked", q.size());
      errors += q.size();
      checks += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
